// File: rtl/thread_scheduler_if.sv
// Scheduler <-> pipeline bundle: stall/redirect/halt requests in, fetch/squash/halt status out.
// master = scheduler side, slave = pipeline side.
`timescale 1ns/1ps
interface thread_scheduler_if #(
    parameter int NTHREADS = 2,
    parameter int TID_W    = 1
);
    logic [NTHREADS-1:0] stall;
    logic                redir_valid;
    logic [TID_W-1:0]    redir_tid;
    logic [15:0]         redir_pc;
    logic                halt_valid;
    logic [TID_W-1:0]    halt_tid;
    logic                fetch_valid;
    logic [TID_W-1:0]    fetch_tid;
    logic [15:0]         fetch_pc;
    logic                squash_valid;
    logic [TID_W-1:0]    squash_tid;
    logic [NTHREADS-1:0] thread_halted;
    logic                halt;

    modport master (
        input  stall, redir_valid, redir_tid, redir_pc, halt_valid, halt_tid,
        output fetch_valid, fetch_tid, fetch_pc, squash_valid, squash_tid,
               thread_halted, halt
    );

    modport slave (
        output stall, redir_valid, redir_tid, redir_pc, halt_valid, halt_tid,
        input  fetch_valid, fetch_tid, fetch_pc, squash_valid, squash_tid,
               thread_halted, halt
    );
endinterface

// File: rtl/thread_scheduler.sv
// Barrel-style round-robin fetch scheduler: per-thread PC and run/halt state, redirect/squash, halt.
// Optional macro SCHED_SKIP_STALLED_EN: issue the first eligible thread instead of strict rotation.
`timescale 1ns/1ps
module thread_scheduler #(
    parameter int          NTHREADS  = 2,
    parameter int          TID_W     = 1,
    parameter logic [15:0] PC_STRIDE = 16'h8000
) (
    input  logic                clk,
    input  logic                reset,
    thread_scheduler_if.master  bus
);

    typedef enum logic {T_RUN = 1'b0, T_HALT = 1'b1} tstate_e;

    tstate_e             tstate_q [NTHREADS];
    tstate_e             tstate_n [NTHREADS];
    logic [15:0]         pc_q     [NTHREADS];
    logic [15:0]         pc_n     [NTHREADS];
    logic [TID_W-1:0]    last_q, last_n;

    logic                vld_p1, vld_n;
    logic [TID_W-1:0]    tid_p1, tid_n;
    logic [15:0]         fpc_p1, fpc_n;
    logic                sq_vld_p1, sq_vld_n;
    logic [TID_W-1:0]    sq_tid_p1, sq_tid_n;
    logic                halt_p1, halt_n;

    logic [NTHREADS-1:0] halting, elig, halted_n, halted_q;
    logic                redir_ok, issue;
    logic [TID_W-1:0]    sel;

    function automatic logic [TID_W-1:0] next_tid(input logic [TID_W-1:0] t, input int step);
        return TID_W'((int'(t) + step) % NTHREADS);
    endfunction

    function automatic logic [15:0] reset_pc(input int t);
        return 16'(t * int'(PC_STRIDE));
    endfunction

    always_comb begin
        tstate_n = tstate_q;
        pc_n     = pc_q;
        last_n   = last_q;
        vld_n    = 1'b0;
        tid_n    = tid_p1;
        fpc_n    = fpc_p1;
        sq_vld_n = 1'b0;
        sq_tid_n = sq_tid_p1;
        redir_ok = 1'b0;

        for (int t = 0; t < NTHREADS; t++)
            halting[t] = bus.halt_valid && (int'(bus.halt_tid) == t) && (tstate_q[t] == T_RUN);

        // A halt on the same thread and edge swallows the redirect entirely.
        if (bus.redir_valid && (int'(bus.redir_tid) < NTHREADS))
            redir_ok = (tstate_q[bus.redir_tid] == T_RUN) &&
                       !(bus.halt_valid && (bus.halt_tid == bus.redir_tid));

        for (int t = 0; t < NTHREADS; t++)
            elig[t] = (tstate_q[t] == T_RUN) && !bus.stall[t] && !halting[t] &&
                      !(redir_ok && (int'(bus.redir_tid) == t));

        sel   = next_tid(last_q, 1);
        issue = elig[sel];
`ifdef SCHED_SKIP_STALLED_EN
        // Walk backwards so the nearest eligible thread after last_q wins.
        issue = 1'b0;
        for (int i = NTHREADS; i >= 1; i--) begin
            if (elig[next_tid(last_q, i)]) begin
                issue = 1'b1;
                sel   = next_tid(last_q, i);
            end
        end
        if (issue)
            last_n = sel;
`else
        last_n = sel;
`endif

        if (issue) begin
            vld_n     = 1'b1;
            tid_n     = sel;
            fpc_n     = pc_q[sel];
            pc_n[sel] = pc_q[sel] + 16'd1;
        end

        if (redir_ok) begin
            pc_n[bus.redir_tid] = bus.redir_pc;
            sq_vld_n            = 1'b1;
            sq_tid_n            = bus.redir_tid;
        end

        for (int t = 0; t < NTHREADS; t++) begin
            if (halting[t])
                tstate_n[t] = T_HALT;
            halted_n[t] = (tstate_n[t] == T_HALT);
            halted_q[t] = (tstate_q[t] == T_HALT);
        end
        halt_n = &halted_n;
    end

    // Stage p1: registered fetch/squash/halt outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int t = 0; t < NTHREADS; t++) begin
                tstate_q[t] <= T_RUN;
                pc_q[t]     <= reset_pc(t);
            end
            last_q    <= TID_W'(NTHREADS - 1);
            vld_p1    <= 1'b0;
            tid_p1    <= '0;
            fpc_p1    <= '0;
            sq_vld_p1 <= 1'b0;
            sq_tid_p1 <= '0;
            halt_p1   <= 1'b0;
        end else begin
            tstate_q  <= tstate_n;
            pc_q      <= pc_n;
            last_q    <= last_n;
            vld_p1    <= vld_n;
            tid_p1    <= tid_n;
            fpc_p1    <= fpc_n;
            sq_vld_p1 <= sq_vld_n;
            sq_tid_p1 <= sq_tid_n;
            halt_p1   <= halt_n;
        end
    end

    assign bus.fetch_valid   = vld_p1;
    assign bus.fetch_tid     = tid_p1;
    assign bus.fetch_pc      = fpc_p1;
    assign bus.squash_valid  = sq_vld_p1;
    assign bus.squash_tid    = sq_tid_p1;
    assign bus.thread_halted = halted_q;
    assign bus.halt          = halt_p1;

endmodule

// File: tb/tb_thread_scheduler.sv
// Scoreboard bench for thread_scheduler: reference model pushes expected fetch/squash/status,
// a monitor pops and compares whenever the DUT presents them.
`timescale 1ns/1ps
module tb_thread_scheduler;
    localparam int          NT     = 2;
    localparam int          TW     = 1;
    localparam logic [15:0] STRIDE = 16'h8000;

    typedef struct {
        int          tid;
        logic [15:0] pc;
    } fe_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    thread_scheduler_if #(.NTHREADS(NT), .TID_W(TW)) bus ();

    thread_scheduler #(.NTHREADS(NT), .TID_W(TW), .PC_STRIDE(STRIDE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    fe_t            fe_q[$];
    int             sq_q[$];
    logic [NT:0]    st_q[$];
    fe_t            log_q[$];

    logic [15:0]    pc_m [NT];
    logic [NT-1:0]  h_m;
    int             last_m;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++) pc_m[t] = 16'(t * int'(STRIDE));
        h_m    = '0;
        last_m = NT - 1;
    endtask

    // Applies one clock edge's worth of scheduling rules to the model.
    task automatic model_step(input logic [NT-1:0] st, input logic rv, input int rt,
                              input logic [15:0] rp, input logic hv, input int ht);
        logic [NT-1:0] halting, elig;
        bit  rok, iss;
        int  sel;
        fe_t e;
        for (int t = 0; t < NT; t++) halting[t] = hv && (ht == t) && !h_m[t];
        rok = 1'b0;
        if (rv && rt < NT) rok = !h_m[rt] && !(hv && ht == rt);
        for (int t = 0; t < NT; t++)
            elig[t] = !h_m[t] && !st[t] && !halting[t] && !(rok && rt == t);
        sel = (last_m + 1) % NT;
        iss = 1'b0;
`ifdef SCHED_SKIP_STALLED_EN
        for (int i = 1; i <= NT; i++) begin
            int c;
            c = (last_m + i) % NT;
            if (!iss && elig[c]) begin
                iss = 1'b1;
                sel = c;
            end
        end
        if (iss) last_m = sel;
`else
        iss    = elig[sel];
        last_m = sel;
`endif
        if (iss) begin
            e.tid = sel;
            e.pc  = pc_m[sel];
            fe_q.push_back(e);
            pc_m[sel] = pc_m[sel] + 16'd1;
        end
        if (rok) begin
            pc_m[rt] = rp;
            sq_q.push_back(rt);
        end
        h_m = h_m | halting;
        st_q.push_back({&h_m, h_m});
    endtask

    task automatic cyc(input logic [NT-1:0] st, input logic rv, input int rt,
                       input logic [15:0] rp, input logic hv, input int ht);
        @(negedge clk);
        bus.stall       = st;
        bus.redir_valid = rv;
        bus.redir_tid   = TW'(rt);
        bus.redir_pc    = rp;
        bus.halt_valid  = hv;
        bus.halt_tid    = TW'(ht);
        model_step(st, rv, rt, rp, hv, ht);
    endtask

    task automatic idle();
        cyc('0, 1'b0, 0, 16'h0, 1'b0, 0);
    endtask

    task automatic rand_cyc(input bit allow_halt);
        logic [NT-1:0] st;
        st = ($urandom % 4 == 0) ? NT'($urandom) : '0;
        cyc(st, ($urandom % 6 == 0), int'($urandom_range(0, 2**TW - 1)), 16'($urandom),
            allow_halt && ($urandom % 30 == 0), int'($urandom_range(0, 2**TW - 1)));
    endtask

    // 1 ns asynchronous reset pulse between edges; outputs must clear immediately.
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_fetch_valid",  32'(bus.fetch_valid), 32'd0);
        chk("rst_fetch_tid",    32'(bus.fetch_tid), 32'd0);
        chk("rst_fetch_pc",     32'(bus.fetch_pc), 32'd0);
        chk("rst_squash_valid", 32'(bus.squash_valid), 32'd0);
        chk("rst_squash_tid",   32'(bus.squash_tid), 32'd0);
        chk("rst_thread_halted",32'(bus.thread_halted), 32'd0);
        chk("rst_halt",         32'(bus.halt), 32'd0);
        fe_q.delete();
        sq_q.delete();
        st_q.delete();
        log_q.delete();
        model_reset();
        reset = 1'b0;
    endtask

    initial begin : monitor
        fe_t         e;
        logic [NT:0] s;
        int          q;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (st_q.size() == 0) chk("status_underflow", 32'd1, 32'd0);
                else begin
                    s = st_q.pop_front();
                    chk("thread_halted", 32'(bus.thread_halted), 32'(s[NT-1:0]));
                    chk("halt", 32'(bus.halt), 32'(s[NT]));
                end
                if (bus.fetch_valid) begin
                    e.tid = int'(bus.fetch_tid);
                    e.pc  = bus.fetch_pc;
                    log_q.push_back(e);
                    if (fe_q.size() == 0) chk("fetch_unexpected", 32'(bus.fetch_pc), 32'hdead);
                    else begin
                        e = fe_q.pop_front();
                        chk("fetch_tid", 32'(bus.fetch_tid), 32'(e.tid));
                        chk("fetch_pc", 32'(bus.fetch_pc), 32'(e.pc));
                    end
                end
                if (bus.squash_valid) begin
                    if (sq_q.size() == 0) chk("squash_unexpected", 32'(bus.squash_tid), 32'hdead);
                    else begin
                        q = sq_q.pop_front();
                        chk("squash_tid", 32'(bus.squash_tid), 32'(q));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int          exp_tid [4];
        logic [15:0] exp_pc  [4];
        exp_tid = '{0, 1, 0, 1};
        exp_pc  = '{16'h0000, 16'h8000, 16'h0001, 16'h8001};
        bus.stall = '0; bus.redir_valid = 1'b0; bus.redir_tid = '0; bus.redir_pc = '0;
        bus.halt_valid = 1'b0; bus.halt_tid = '0;

        do_reset();
        mon_en = 1'b1;

        // Plain rotation from reset, then two edges with t1 stalled.
        repeat (4) idle();
        cyc(2'b10, 1'b0, 0, 16'h0, 1'b0, 0);
        chk("log_size_t1", 32'(log_q.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) begin
            if (i < log_q.size()) begin
                chk("first_tid", 32'(log_q[i].tid), 32'(exp_tid[i]));
                chk("first_pc", 32'(log_q[i].pc), 32'(exp_pc[i]));
            end
        end
        cyc(2'b10, 1'b0, 0, 16'h0, 1'b0, 0);

        // Redirect t0 on the edge it is the rotation candidate.
        while (((last_m + 1) % NT) != 0) idle();
        cyc('0, 1'b1, 0, 16'h0123, 1'b0, 0);
        repeat (4) idle();

        repeat (200) rand_cyc(1'b0);

        // PC wrap after redirect to FFFF.
        cyc('0, 1'b1, 0, 16'hFFFF, 1'b0, 0);
        repeat (5) idle();

        // Mid-run reset; first issue afterwards must be (t0,0000).
        repeat (3) rand_cyc(1'b0);
        do_reset();
        idle();
        idle();
        chk("post_reset_log", 32'(log_q.size() >= 1), 32'd1);
        if (log_q.size() >= 1) begin
            chk("post_reset_tid", 32'(log_q[0].tid), 32'd0);
            chk("post_reset_pc", 32'(log_q[0].pc), 32'h0000);
        end

        // Halt t1, ignored redirect to halted t1, then halt+redirect t0 together.
        cyc('0, 1'b0, 0, 16'h0, 1'b1, 1);
        repeat (3) idle();
        cyc('0, 1'b1, 1, 16'h0055, 1'b0, 0);
        cyc('0, 1'b1, 0, 16'h0123, 1'b1, 0);
        repeat (6) idle();
        chk("halt_final", 32'(bus.halt), 32'd1);
        chk("halted_final", 32'(bus.thread_halted), 32'(2'b11));
        repeat (20) rand_cyc(1'b1);

        do_reset();
        repeat (150) rand_cyc(1'b1);
        repeat (2) idle();

        @(posedge clk);
        #2;
        chk("fetch_q_left", 32'(fe_q.size()), 32'd0);
        chk("squash_q_left", 32'(sq_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
